multi_clk_divider: RTL and testbench

//  NUM_CH-channel programmable clock divider driven from the 40 MHz board clock.

---
 rtl/clk_div_pkg.sv | 20 ++
 rtl/clk_div_channel.sv | 70 +++++++
 rtl/multi_clk_divider.sv | 56 +++++
 tb/tb_multi_clk_divider.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// ============================================================================
// clk_div_pkg : shared constants and helpers for the multi-channel clock divider
// Rev 1.0
// ============================================================================
`default_nettype none

package clk_div_pkg;

  localparam int unsigned CNT_W_DEF = 25;
  localparam logic [CNT_W_DEF-1:0] DEFAULT_HALF_DEF = 25'd19999999;
  localparam int unsigned CLK_HZ = 40_000_000;

  // Half-period terminal count that yields an output of 'hz' from CLK_HZ.
  function automatic logic [CNT_W_DEF-1:0] half_for_hz(input int unsigned hz);
    return CNT_W_DEF'(CLK_HZ / (2 * hz) - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/clk_div_channel.sv
// ============================================================================
// clk_div_channel : one 50%-duty divider with glitch-free half-period reload
// Rev 1.0
// ============================================================================
`default_nettype none

module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int unsigned      CNT_W        = CNT_W_DEF,
  parameter logic [CNT_W-1:0] DEFAULT_HALF = CNT_W'(DEFAULT_HALF_DEF)
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             sync,
  input  logic             en,
  input  logic             accept,
  input  logic [CNT_W-1:0] cfg_half,
  output logic             pending,
  output logic             divided_clk,
  output logic             tick
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] half;
  logic [CNT_W-1:0] shadow;
  logic             at_term;

  assign at_term = (cnt == half);

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      half        <= DEFAULT_HALF;
      shadow      <= DEFAULT_HALF;
      pending     <= 1'b0;
      divided_clk <= 1'b0;
      tick        <= 1'b0;
    end else begin
      if (sync || !en) begin
        cnt         <= '0;
        divided_clk <= 1'b0;
        tick        <= 1'b0;
        if (pending) begin
          half    <= shadow;
          pending <= 1'b0;
        end
      end else if (at_term) begin
        cnt         <= '0;
        divided_clk <= ~divided_clk;
        tick        <= ~divided_clk;
        if (pending) begin
          half    <= shadow;
          pending <= 1'b0;
        end
      end else begin
        cnt  <= cnt + CNT_W'(1);
        tick <= 1'b0;
      end
      // Accept only occurs with pending clear, so it never races a reload.
      if (accept) begin
        shadow  <= cfg_half;
        pending <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/multi_clk_divider.sv
// ============================================================================
// multi_clk_divider : NUM_CH programmable clock dividers with a shared cfg port
// Rev 1.0
// ============================================================================
`default_nettype none

module multi_clk_divider
  import clk_div_pkg::*;
#(
  parameter int unsigned      NUM_CH       = 2,
  parameter int unsigned      CNT_W        = CNT_W_DEF,
  parameter logic [CNT_W-1:0] DEFAULT_HALF = CNT_W'(DEFAULT_HALF_DEF),
  localparam int unsigned     CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              sync,
  input  logic [NUM_CH-1:0] en,
  input  logic              cfg_valid,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_half,
  output logic              cfg_ready,
  output logic [NUM_CH-1:0] divided_clk,
  output logic [NUM_CH-1:0] tick
);

  logic [NUM_CH-1:0] sel;
  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] accept;

  // An out-of-range channel selects nothing: ready stays high, write is dropped.
  assign cfg_ready = ~|(sel & pending);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign sel[i]    = (cfg_ch == CH_W'(i));
    assign accept[i] = cfg_valid & sel[i] & ~pending[i];

    clk_div_channel #(
      .CNT_W        (CNT_W),
      .DEFAULT_HALF (DEFAULT_HALF)
    ) u_channel (
      .clk_in      (clk_in),
      .rst         (rst),
      .sync        (sync),
      .en          (en[i]),
      .accept      (accept[i]),
      .cfg_half    (cfg_half),
      .pending     (pending[i]),
      .divided_clk (divided_clk[i]),
      .tick        (tick[i])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_multi_clk_divider.sv
// ============================================================================
// tb_multi_clk_divider : directed + random bench against a half-period model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_multi_clk_divider;

  logic       clk_in = 1'b0;
  logic       rst;
  logic       sync;
  logic [1:0] en;
  logic       cfg_valid;
  logic [0:0] cfg_ch;
  logic [7:0] cfg_half;
  logic       cfg_ready;
  logic [1:0] divided_clk;
  logic [1:0] tick;

  int checks = 0;
  int errors = 0;

  // Model: remaining cycles in the current half-period, output level, reload slot.
  int m_half[2];
  int m_shadow[2];
  int m_left[2];
  bit m_lvl[2];
  bit m_tick[2];
  bit m_pend[2];

  always #5 clk_in = ~clk_in;

  multi_clk_divider #(
    .NUM_CH       (2),
    .CNT_W        (8),
    .DEFAULT_HALF (8'd3)
  ) dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .sync        (sync),
    .en          (en),
    .cfg_valid   (cfg_valid),
    .cfg_ch      (cfg_ch),
    .cfg_half    (cfg_half),
    .cfg_ready   (cfg_ready),
    .divided_clk (divided_clk),
    .tick        (tick)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_half[i]   = 3;
      m_shadow[i] = 3;
      m_left[i]   = 4;
      m_lvl[i]    = 1'b0;
      m_tick[i]   = 1'b0;
      m_pend[i]   = 1'b0;
    end
  endtask

  task automatic model_cycle(input int i, input bit acc);
    m_tick[i] = 1'b0;
    if (sync || !en[i]) begin
      if (m_pend[i]) begin
        m_half[i] = m_shadow[i];
        m_pend[i] = 1'b0;
      end
      m_lvl[i]  = 1'b0;
      m_left[i] = m_half[i] + 1;
    end else begin
      m_left[i]--;
      if (m_left[i] == 0) begin
        m_lvl[i]  = !m_lvl[i];
        m_tick[i] = m_lvl[i];
        if (m_pend[i]) begin
          m_half[i] = m_shadow[i];
          m_pend[i] = 1'b0;
        end
        m_left[i] = m_half[i] + 1;
      end
    end
    if (acc) begin
      m_shadow[i] = int'(cfg_half);
      m_pend[i]   = 1'b1;
    end
  endtask

  // One clock: check ready, advance the model at the edge, check registered outputs.
  task automatic step();
    bit acc[2];
    #1;
    check("cfg_ready", cfg_ready, !m_pend[cfg_ch]);
    for (int i = 0; i < 2; i++)
      acc[i] = cfg_valid && (int'(cfg_ch) == i) && !m_pend[i];
    @(posedge clk_in);
    if (rst) model_reset();
    else for (int i = 0; i < 2; i++) model_cycle(i, acc[i]);
    #1;
    check("divided_clk", divided_clk, {m_lvl[1], m_lvl[0]});
    check("tick", tick, {m_tick[1], m_tick[0]});
    @(negedge clk_in);
  endtask

  task automatic wait_tick(input int ch, input int exp_n, input string tag);
    int n = 0;
    do begin
      step();
      n++;
    end while (tick[ch] !== 1'b1 && n < 40);
    check(tag, n, exp_n);
  endtask

  task automatic wait_state(input int ch, input int lvl, input int left, input string tag);
    int n = 0;
    while (!((lvl < 0 || int'(m_lvl[ch]) == lvl) && m_left[ch] == left) && n < 40) begin
      step();
      n++;
    end
    check(tag, n < 40, 1);
  endtask

  initial begin
    rst = 1'b1; sync = 1'b0; en = 2'b00;
    cfg_valid = 1'b0; cfg_ch = 1'b0; cfg_half = 8'd0;
    model_reset();
    @(negedge clk_in);
    @(negedge clk_in);
    check("reset_clk", divided_clk, 0);
    check("reset_tick", tick, 0);
    check("reset_ready", cfg_ready, 1);

    // 1: default half=3 -> first rise after 4, period 8
    rst = 1'b0; en = 2'b11;
    wait_tick(0, 4, "first_rise_ch0");
    wait_tick(0, 8, "period_ch0");

    // 2: ch1 half=0 requested mid-low-phase
    wait_state(1, 0, 2, "reach_mid_low_ch1");
    cfg_valid = 1'b1; cfg_ch = 1'b1; cfg_half = 8'd0;
    step();
    cfg_valid = 1'b0;
    #1 check("ready_drop", cfg_ready, 0);
    wait_tick(1, 1, "low_completes_ch1");
    check("ready_return", cfg_ready, 1);
    wait_tick(1, 2, "fast_period_ch1_a");
    wait_tick(1, 2, "fast_period_ch1_b");
    cfg_valid = 1'b1; cfg_half = 8'd3;
    step();
    cfg_valid = 1'b0;
    repeat (3) step();

    // 3: disable ch0 for 10 cycles, then re-enable
    en = 2'b10;
    repeat (10) step();
    check("disabled_out0", divided_clk[0], 0);
    en = 2'b11;
    wait_tick(0, 4, "reenable_rise_ch0");

    // 4: ch1 half=5 pending, sync with ch0 at cnt=2
    wait_state(0, -1, 3, "reach_cnt1_ch0");
    cfg_valid = 1'b1; cfg_ch = 1'b1; cfg_half = 8'd5;
    step();
    cfg_valid = 1'b0;
    check("pending_before_sync", cfg_ready, 0);
    sync = 1'b1;
    step();
    sync = 1'b0;
    check("sync_clk", divided_clk, 0);
    wait_tick(1, 6, "sync_first_rise_ch1");
    wait_tick(1, 12, "sync_period_ch1");

    // 5: reset with a pending config
    cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_half = 8'd1;
    step();
    cfg_valid = 1'b0;
    rst = 1'b1;
    #1;
    model_reset();
    check("async_rst_clk", divided_clk, 0);
    check("async_rst_tick", tick, 0);
    check("rst_clears_pending", cfg_ready, 1);
    repeat (2) step();
    rst = 1'b0;
    wait_tick(0, 4, "post_rst_rise_ch0");
    wait_tick(0, 8, "post_rst_period_ch0");

    // 6: accept exactly on a rising toggle of ch0
    wait_state(0, 0, 1, "reach_toggle_ch0");
    cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_half = 8'd1;
    step();
    cfg_valid = 1'b0;
    check("toggle_cycle_tick", tick[0], 1);
    wait_tick(0, 6, "old_half_then_new");
    wait_tick(0, 4, "new_period_ch0");

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      en        = ($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'b11;
      sync      = ($urandom_range(0, 24) == 0);
      cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_ch    = 1'($urandom);
      cfg_half  = 8'($urandom_range(0, 7));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
